branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 The block SHALL have these ports, one per line, as name direction width meaning:
  - clk  in  1  clock; all state on rising edge.
  - reset  in  1  synchronous, active-high.
  - f_valid  in  1  fetch issued a predicted instruction this cycle.
  - f_pc  in  32  fetched PC.
  - f_pred_taken  in  1  predictor taken bit.
  - f_pred_pc  in  32  predictor next-PC.
  - f_index  in  5  BTB/BHT index used for the prediction.
  - r_valid  in  1  oldest in-flight instruction resolved in EX.
  - r_is_branch  in  1  resolved instruction is a branch/jump.
  - r_taken  in  1  actual direction.
  - r_target  in  32  actual taken target.
  - fifo_full  out  1  fetch must stall.
  - btb_update  out  1  write BTB entry.
  - write_index  out  5  BTB/BHT index to update.
  - tag_write  out  32  tag (full PC) to write.
  - real_pc  out  32  target to write.
  - real_taken  out  2  2'b01 taken, 2'b00 not taken, 2'b10 no update.
  - redirect  out  1  mispredict; fetch restarts at redirect_pc.
  - redirect_pc  out  32  correct next PC.
  - flush  out  1  squash IF/ID/EX.
  - branch_cnt  out  16  resolved branches, saturating.
  - mispredict_cnt  out  16  mispredicts, saturating.
  - err  out  1  sticky: r_valid with empty queue.

Function
REQ-002 An in-flight queue SHALL hold 4 entries {pc, pred_taken, pred_pc, index}, FIFO order.
REQ-003 Push SHALL occur when f_valid=1, fifo_full=0 and state=NORMAL; fifo_full=1 iff count=4.
REQ-004 Pop SHALL occur when r_valid=1, count>0 and state=NORMAL; push and pop in the same cycle SHALL both occur, including at count=4 only if fifo_full was 0 that cycle (no push when full).
REQ-005 For a popped entry: actual_next = (r_is_branch & r_taken) ? r_target : pc+4, with 32-bit wrap-around on pc+4.
REQ-006 Mispredict SHALL be actual_next != pred_pc.
REQ-007 All update outputs SHALL be registered, asserted exactly the cycle after the pop, and held for 1 cycle.
REQ-008 For a branch: real_taken = {0,r_taken} and write_index = index. btb_update SHALL equal r_taken; tag_write = pc; real_pc = r_target.
REQ-009 For a non-branch, or a cycle with no pop: real_taken = 2'b10 and btb_update = 0.
REQ-010 On mispredict: redirect=1 and redirect_pc=actual_next for 1 cycle; flush=1 that cycle; the queue SHALL be cleared at the same edge, and any same-cycle push SHALL be dropped.
REQ-011 The FSM SHALL have states NORMAL and FLUSH. NORMAL->FLUSH on mispredict. FLUSH lasts 2 cycles (2-bit counter), with flush=1 throughout, then returns to NORMAL. In FLUSH, f_valid and r_valid SHALL be ignored.
REQ-012 branch_cnt SHALL increment per branch pop and mispredict_cnt per mispredict (branch or not); both SHALL saturate at 16'hFFFF.
REQ-013 r_valid in NORMAL with count=0 SHALL set err=1 until reset, with no pop and no outputs.

Reset
REQ-014 With reset=1 at an edge: count=0, pointers=0, state=NORMAL, counters=0, err=0. Outputs SHALL reset to btb_update=0, real_taken=2'b10, redirect=0, flush=0, and data outputs=0.
REQ-015 Reset mid-FLUSH or with a non-empty queue SHALL discard everything; reset has priority over push/pop.

Structure
REQ-016 A shared package SHALL hold QDEPTH=4, FLUSH_CYCLES=2, the REAL_TAKEN codes (TK=2'b01, NT=2'b00, NONE=2'b10) and the FSM state enum.
REQ-017 The queue SHALL be a sub-module pred_fifo (4x70-bit, count, clear input); all other logic lives in branch_resolver.

Verification
REQ-018 Scenario: push pc=0x100, pred_taken=1, pred_pc=0x200, idx=3; resolve branch, taken, target=0x200. Required next cycle: btb_update=1, write_index=3, tag_write=0x100, real_pc=0x200, real_taken=01, redirect=0.
REQ-019 Scenario: push pc=0x104, pred_pc=0x108; resolve branch, taken, target=0x300. Required: redirect=1, redirect_pc=0x300, flush=1 for 3 cycles, queue empty, mispredict_cnt=1.
REQ-020 Scenario: 4 pushes with no pops. Required: fifo_full=1. A 5th f_valid is dropped; a simultaneous pop then lowers fifo_full the next cycle.
REQ-021 Scenario: push pc=0xFFFFFFFC, pred_pc=0; resolve non-branch. Required: no redirect (wrap), real_taken=10.
REQ-022 Scenario: r_valid with empty queue. Required: err=1, sticky until reset; reset asserted during FLUSH returns state to NORMAL with flush=0 next cycle.
REQ-023 Scenario: preload branch_cnt=16'hFFFF via 65535 resolves, then one more branch resolve. Required: branch_cnt remains 16'hFFFF.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolver and its prediction queue.
package branch_resolver_pkg;

    localparam int QDEPTH = 4;
    localparam int PTR_W  = $clog2(QDEPTH);
    localparam int CNT_W  = $clog2(QDEPTH + 1);

    localparam logic [1:0] FLUSH_CYCLES = 2'd2;

    localparam logic [1:0] RT_TK   = 2'b01;
    localparam logic [1:0] RT_NT   = 2'b00;
    localparam logic [1:0] RT_NONE = 2'b10;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FLUSH  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_pc;
        logic [4:0]  index;
    } pred_entry_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-flight prediction queue: 4 x 70-bit FIFO, head readable combinationally.
// Push is ignored when full and pop when empty; clear empties it at the next edge.
module pred_fifo
    import branch_resolver_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  pred_entry_t      push_dat_i,
    input  logic             pop_i,
    output pred_entry_t      head_dat_o,
    output logic [CNT_W-1:0] count_o
);

    pred_entry_t      mem_q [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    // A full queue refuses the push even when a pop frees a slot that cycle.
    assign do_push = push_i && (count_q != CNT_W'(QDEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/branch_resolver.sv
// Matches resolved instructions against queued predictions; BTB/redirect outputs registered, 1 cycle after pop.
// Fetch stalls on fifo_full; a mispredict clears the queue and holds both sides off for the FLUSH window.
module branch_resolver
    import branch_resolver_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        f_valid,
    input  logic [31:0] f_pc,
    input  logic        f_pred_taken,
    input  logic [31:0] f_pred_pc,
    input  logic [4:0]  f_index,
    input  logic        r_valid,
    input  logic        r_is_branch,
    input  logic        r_taken,
    input  logic [31:0] r_target,
    output logic        fifo_full,
    output logic        btb_update,
    output logic [4:0]  write_index,
    output logic [31:0] tag_write,
    output logic [31:0] real_pc,
    output logic [1:0]  real_taken,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [15:0] branch_cnt,
    output logic [15:0] mispredict_cnt,
    output logic        err
);

    state_t           state_q;
    logic [1:0]       flush_cnt_q;
    pred_entry_t      head;
    pred_entry_t      push_dat;
    logic [CNT_W-1:0] count;
    logic             normal, pop, push, mispredict;
    logic [31:0]      actual_next;
    logic             unused_pred_taken;

    assign normal      = (state_q == ST_NORMAL);
    assign fifo_full   = (count == CNT_W'(QDEPTH));
    assign pop         = r_valid && normal && (count != '0);
    assign actual_next = (r_is_branch && r_taken) ? r_target : head.pc + 32'd4;
    assign mispredict  = pop && (actual_next != head.pred_pc);
    // A push racing a mispredict belongs to the wrong path, so it is dropped.
    assign push        = f_valid && !fifo_full && normal && !mispredict;
    assign push_dat    = '{pc: f_pc, pred_taken: f_pred_taken, pred_pc: f_pred_pc, index: f_index};
    assign unused_pred_taken = head.pred_taken;

    pred_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (mispredict),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (head),
        .count_o    (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_NORMAL;
            flush_cnt_q    <= '0;
            btb_update     <= 1'b0;
            write_index    <= '0;
            tag_write      <= '0;
            real_pc        <= '0;
            real_taken     <= RT_NONE;
            redirect       <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
            err            <= 1'b0;
        end else begin
            btb_update <= 1'b0;
            real_taken <= RT_NONE;
            redirect   <= 1'b0;
            // Lags the state by one cycle, so flush spans the redirect cycle plus the FLUSH window.
            flush      <= mispredict || (state_q == ST_FLUSH);

            if (pop) begin
                write_index <= head.index;
                tag_write   <= head.pc;
                real_pc     <= r_target;
                if (r_is_branch) begin
                    btb_update <= r_taken;
                    real_taken <= r_taken ? RT_TK : RT_NT;
                    branch_cnt <= sat_inc(branch_cnt);
                end
            end

            if (mispredict) begin
                redirect       <= 1'b1;
                redirect_pc    <= actual_next;
                mispredict_cnt <= sat_inc(mispredict_cnt);
            end

            if (r_valid && normal && (count == '0)) err <= 1'b1;

            case (state_q)
                ST_NORMAL: begin
                    if (mispredict) begin
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == FLUSH_CYCLES - 2'd1) state_q <= ST_NORMAL;
                    else flush_cnt_q <= flush_cnt_q + 2'd1;
                end
                default: state_q <= ST_NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: a reference model predicts each cycle's registered outputs.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        reset, f_valid, f_pred_taken, r_valid, r_is_branch, r_taken;
    logic [31:0] f_pc, f_pred_pc, r_target;
    logic [4:0]  f_index;
    logic        fifo_full, btb_update, redirect, flush, err;
    logic [4:0]  write_index;
    logic [31:0] tag_write, real_pc, redirect_pc;
    logic [1:0]  real_taken;
    logic [15:0] branch_cnt, mispredict_cnt;

    always #5 clk = ~clk;

    branch_resolver dut (
        .clk(clk), .reset(reset), .f_valid(f_valid), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
        .f_pred_pc(f_pred_pc), .f_index(f_index), .r_valid(r_valid), .r_is_branch(r_is_branch),
        .r_taken(r_taken), .r_target(r_target), .fifo_full(fifo_full), .btb_update(btb_update),
        .write_index(write_index), .tag_write(tag_write), .real_pc(real_pc), .real_taken(real_taken),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .branch_cnt(branch_cnt),
        .mispredict_cnt(mispredict_cnt), .err(err)
    );

    typedef struct packed {
        logic        btb;
        logic [4:0]  idx;
        logic [31:0] tag;
        logic [31:0] rpc;
        logic [1:0]  rt;
        logic        redir;
        logic [31:0] rdpc;
        logic        flush;
        logic        full;
        logic        err;
        logic [15:0] bcnt;
        logic [15:0] mcnt;
    } out_t;

    typedef struct packed { out_t exp; out_t mask; } sb_t;

    typedef struct packed {
        logic rst; logic fv; logic [31:0] pc; logic pt; logic [31:0] ppc; logic [4:0] idx;
        logic rv; logic br; logic tk; logic [31:0] tgt;
    } stim_t;

    typedef struct packed { logic [31:0] pc; logic [31:0] ppc; logic [4:0] idx; } ent_t;

    sb_t         sb[$];
    ent_t        m_q[$];
    int          m_fsm = 0;
    logic        m_err = 1'b0;
    logic [15:0] m_bcnt = '0, m_mcnt = '0;
    int          checks = 0, errors = 0;

    function automatic stim_t mk(logic rst, logic fv, logic [31:0] pc, logic pt, logic [31:0] ppc,
                                 logic [4:0] idx, logic rv, logic br, logic tk, logic [31:0] tgt);
        stim_t s;
        s.rst = rst; s.fv = fv; s.pc = pc; s.pt = pt; s.ppc = ppc; s.idx = idx;
        s.rv = rv; s.br = br; s.tk = tk; s.tgt = tgt;
        return s;
    endfunction

    function automatic out_t get_obs();
        out_t o;
        o.btb = btb_update; o.idx = write_index; o.tag = tag_write; o.rpc = real_pc;
        o.rt = real_taken; o.redir = redirect; o.rdpc = redirect_pc; o.flush = flush;
        o.full = fifo_full; o.err = err; o.bcnt = branch_cnt; o.mcnt = mispredict_cnt;
        return o;
    endfunction

    // Drive one cycle, advance the reference model and queue the outputs expected after the edge.
    task automatic cyc(input stim_t s);
        out_t x, m;
        ent_t e;
        logic normal, pop, mis;
        logic [31:0] actual;
        int sz;
        reset = s.rst; f_valid = s.fv; f_pc = s.pc; f_pred_taken = s.pt; f_pred_pc = s.ppc;
        f_index = s.idx; r_valid = s.rv; r_is_branch = s.br; r_taken = s.tk; r_target = s.tgt;
        x = '0; m = '1; x.rt = 2'b10;
        if (s.rst) begin
            m_q.delete(); m_fsm = 0; m_err = 1'b0; m_bcnt = '0; m_mcnt = '0;
        end else begin
            m.idx = '0; m.tag = '0; m.rpc = '0; m.rdpc = '0;
            normal = (m_fsm == 0);
            sz = m_q.size();
            pop = s.rv && normal && sz > 0;
            mis = 1'b0;
            if (s.rv && normal && sz == 0) m_err = 1'b1;
            if (pop) begin
                e = m_q.pop_front();
                actual = (s.br && s.tk) ? s.tgt : e.pc + 32'd4;
                mis = (actual != e.ppc);
                if (s.br) begin
                    x.btb = s.tk; x.rt = {1'b0, s.tk};
                    x.idx = e.idx; x.tag = e.pc; x.rpc = s.tgt;
                    m.idx = '1; m.tag = '1; m.rpc = '1;
                    if (m_bcnt != 16'hFFFF) m_bcnt++;
                end
                if (mis) begin
                    x.redir = 1'b1; x.rdpc = actual; m.rdpc = '1;
                    if (m_mcnt != 16'hFFFF) m_mcnt++;
                end
            end
            x.flush = mis || (m_fsm > 0);
            if (s.fv && normal && sz < 4 && !mis) m_q.push_back('{pc: s.pc, ppc: s.ppc, idx: s.idx});
            if (m_fsm > 0) m_fsm--;
            else if (mis) m_fsm = 2;
            if (mis) m_q.delete();
        end
        x.full = (m_q.size() == 4); x.err = m_err; x.bcnt = m_bcnt; x.mcnt = m_mcnt;
        sb.push_back('{exp: x, mask: m});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s[$];
        sb_t   e;
        out_t  o;
        s.push_back(mk(1, 1, 32'h55, 1, 32'h66, 5'd9, 1, 1, 1, 32'h77));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            cyc(s[i]);
            e = sb.pop_front(); o = get_obs(); checks++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                errors++; $display("FAIL reset[%0d] got %h want %h", i, o, e.exp);
            end
        end
        checks++;
        if ({btb_update, real_taken, redirect, flush, err, branch_cnt, tag_write} !== {1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0}) begin
            errors++; $display("FAIL reset_const got btb=%b rt=%b redir=%b flush=%b err=%b", btb_update, real_taken, redirect, flush, err);
        end
    endtask

    task automatic test_hit();
        stim_t s[$];
        sb_t   e;
        out_t  o;
        s.push_back(mk(0, 1, 32'h100, 1, 32'h200, 5'd3, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h200));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            cyc(s[i]);
            e = sb.pop_front(); o = get_obs(); checks++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                errors++; $display("FAIL hit[%0d] got %h want %h", i, o, e.exp);
            end
            if (i == 1) begin
                checks++;
                if ({btb_update, write_index, tag_write, real_pc, real_taken, redirect} !== {1'b1, 5'd3, 32'h100, 32'h200, 2'b01, 1'b0}) begin
                    errors++; $display("FAIL hit_const got btb=%b idx=%0d tag=%h rpc=%h rt=%b redir=%b", btb_update, write_index, tag_write, real_pc, real_taken, redirect);
                end
            end
        end
    endtask

    task automatic test_mispredict();
        stim_t s[$];
        sb_t   e;
        out_t  o;
        s.push_back(mk(0, 1, 32'h104, 1, 32'h108, 5'd4, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 32'h900, 0, 32'h904, 5'd5, 1, 1, 1, 32'h300));
        s.push_back(mk(0, 1, 32'hA00, 0, 32'hA04, 5'd6, 1, 1, 0, 0));
        s.push_back(mk(0, 1, 32'hA10, 0, 32'hA14, 5'd6, 1, 1, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 32'h300, 0, 32'h304, 5'd7, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0));
        foreach (s[i]) begin
            cyc(s[i]);
            e = sb.pop_front(); o = get_obs(); checks++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                errors++; $display("FAIL mispredict[%0d] got %h want %h", i, o, e.exp);
            end
            if (i == 1) begin
                checks++;
                if ({redirect, redirect_pc, flush, mispredict_cnt} !== {1'b1, 32'h300, 1'b1, 16'd1}) begin
                    errors++; $display("FAIL mispredict_const got redir=%b pc=%h flush=%b mcnt=%0d", redirect, redirect_pc, flush, mispredict_cnt);
                end
            end
            if (i == 3 || i == 4) begin
                checks++;
                if (flush !== (i == 3)) begin
                    errors++; $display("FAIL flush_len[%0d] got %b want %b", i, flush, i == 3);
                end
            end
            if (i == 6) begin
                checks++;
                if (tag_write !== 32'h300) begin
                    errors++; $display("FAIL queue_cleared got tag=%h want 300", tag_write);
                end
            end
        end
    endtask

    task automatic test_full();
        stim_t s[$];
        sb_t   e;
        out_t  o;
        for (int k = 0; k < 4; k++)
            s.push_back(mk(0, 1, 32'h400 + 32'(4 * k), 0, 32'h404 + 32'(4 * k), 5'(k), 0, 0, 0, 0));
        s.push_back(mk(0, 1, 32'h500, 0, 32'h504, 5'd9, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 32'h600, 0, 32'h604, 5'd10, 1, 1, 0, 32'h0));
        for (int k = 0; k < 3; k++) s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0));
        foreach (s[i]) begin
            cyc(s[i]);
            e = sb.pop_front(); o = get_obs(); checks++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                errors++; $display("FAIL full[%0d] got %h want %h", i, o, e.exp);
            end
            if (i == 3 || i == 4) begin
                checks++;
                if (fifo_full !== 1'b1) begin errors++; $display("FAIL full_set[%0d] got %b want 1", i, fifo_full); end
            end
            if (i == 5) begin
                checks++;
                if ({fifo_full, tag_write} !== {1'b0, 32'h400}) begin
                    errors++; $display("FAIL full_pop got full=%b tag=%h want 0 400", fifo_full, tag_write);
                end
            end
            if (i == 8) begin
                checks++;
                if (tag_write !== 32'h40C) begin errors++; $display("FAIL full_order got tag=%h want 40c", tag_write); end
            end
            if (i == 10) begin
                checks++;
                if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err); end
            end
        end
    endtask

    task automatic test_wrap();
        stim_t s[$];
        sb_t   e;
        out_t  o;
        s.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 5'd31, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hDEAD));
        s.push_back(mk(0, 1, 32'h800, 1, 32'h900, 5'd2, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h900));
        for (int k = 0; k < 3; k++) s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            cyc(s[i]);
            e = sb.pop_front(); o = get_obs(); checks++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                errors++; $display("FAIL wrap[%0d] got %h want %h", i, o, e.exp);
            end
            if (i == 1) begin
                checks++;
                if ({redirect, real_taken, btb_update} !== {1'b0, 2'b10, 1'b0}) begin
                    errors++; $display("FAIL wrap_const got redir=%b rt=%b btb=%b", redirect, real_taken, btb_update);
                end
            end
            if (i == 3) begin
                checks++;
                if ({redirect, redirect_pc, real_taken} !== {1'b1, 32'h804, 2'b10}) begin
                    errors++; $display("FAIL nonbranch_redirect got redir=%b pc=%h rt=%b want 1 804 10", redirect, redirect_pc, real_taken);
                end
            end
        end
    endtask

    task automatic test_err_reset();
        stim_t s[$];
        sb_t   e;
        out_t  o;
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 1, 32'h10, 0, 32'h14, 5'd1, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h80));
        s.push_back(mk(1, 1, 32'h30, 0, 32'h34, 5'd2, 1, 1, 0, 0));
        s.push_back(mk(0, 1, 32'h20, 0, 32'h24, 5'd8, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0));
        foreach (s[i]) begin
            cyc(s[i]);
            e = sb.pop_front(); o = get_obs(); checks++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                errors++; $display("FAIL err_reset[%0d] got %h want %h", i, o, e.exp);
            end
            if (i == 0) begin
                checks++;
                if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
            end
            if (i == 3) begin
                checks++;
                if ({flush, err, redirect, fifo_full} !== 4'b0000) begin
                    errors++; $display("FAIL reset_in_flush got flush=%b err=%b redir=%b full=%b", flush, err, redirect, fifo_full);
                end
            end
            if (i == 5) begin
                checks++;
                if ({tag_write, write_index} !== {32'h20, 5'd8}) begin
                    errors++; $display("FAIL post_reset got tag=%h idx=%0d want 20 8", tag_write, write_index);
                end
            end
        end
    endtask

    task automatic test_saturation();
        sb_t  e;
        out_t o;
        int   shown = 0;
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        void'(sb.pop_front());
        cyc(mk(0, 1, 32'h0, 0, 32'h4, 5'd1, 0, 0, 0, 0));
        void'(sb.pop_front());
        for (int k = 0; k < 65536; k++) begin
            cyc(mk(0, 1, 32'h0, 0, 32'h4, 5'd1, 1, 1, 0, 32'h0));
            e = sb.pop_front(); o = get_obs(); checks++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                errors++;
                if (shown < 8) begin shown++; $display("FAIL sat[%0d] got %h want %h", k, o, e.exp); end
            end
            if (k == 65534 || k == 65535) begin
                checks++;
                if ({branch_cnt, mispredict_cnt} !== {16'hFFFF, 16'h0}) begin
                    errors++; $display("FAIL sat_const[%0d] got bcnt=%h mcnt=%h want ffff 0", k, branch_cnt, mispredict_cnt);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_mispredict();
        test_full();
        test_wrap();
        test_err_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
